// File: rtl/z180_gpio_bank.sv
// z180_gpio_bank: multi-port GPIO with synchronised inputs, edge-detect sticky flags and active-low interrupt
module z180_gpio_bank #(
  parameter logic [7:0] BASE_ADDR = 8'h60,
  parameter int N_PORTS = 2,
  parameter int WIDTH = 8,
  parameter bit IFLAG_RC = 1'b0
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic [7:0]                 addr,
  input  logic                       iorq_rd,
  input  logic                       rd_stb,
  input  logic                       wr_stb,
  input  logic [7:0]                 wdata,
  output logic                       rd_hit,
  output logic [7:0]                 rdata,
  input  logic [N_PORTS*WIDTH-1:0]   pin_in,
  output logic [N_PORTS*WIDTH-1:0]   pin_out,
  output logic [N_PORTS*WIDTH-1:0]   pin_oe,
  output logic                       int_n
);
  localparam int NW = N_PORTS * WIDTH;
  localparam logic [8:0] TOP = 9'(BASE_ADDR) + 9'(8 * N_PORTS);
  logic [2:0] sel, off;
  logic hit;
  logic [NW-1:0] out_q, dir_q, ie_q, edge_q, flag_q, s1, s2, s3;
  logic [NW-1:0] out_n, dir_n, ie_n, edge_n, set, clr;
  logic [N_PORTS-1:0][7:0] rd_mux;
  assign sel = 3'((addr - BASE_ADDR) >> 3);
  assign off = addr[2:0];
  assign hit = addr >= BASE_ADDR && {1'b0, addr} < TOP;
  assign rd_hit = iorq_rd && hit && off < 3'd6;
  assign pin_out = out_q;
  assign pin_oe = dir_q;
  assign set = ie_q & ((edge_q & ~s2 & s3) | (~edge_q & s2 & ~s3));
  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    localparam int L = p * WIDTH;
    logic sel_p, wr_p;
    logic [WIDTH-1:0] o, d, v;
    assign sel_p = hit && sel == 3'(p);
    assign wr_p = wr_stb && sel_p;
    assign o = out_q[L +: WIDTH];
    assign d = dir_q[L +: WIDTH];
    assign v = (d & o) | (~d & s2[L +: WIDTH]);
    assign rd_mux[p] = off == 3'd0 ? 8'(v) :
                       off == 3'd1 ? 8'(d) :
                       off == 3'd2 ? 8'(o) :
                       off == 3'd3 ? 8'(ie_q[L +: WIDTH]) :
                       off == 3'd4 ? 8'(edge_q[L +: WIDTH]) : 8'(flag_q[L +: WIDTH]);
    assign out_n[L +: WIDTH] = wr_p && (off == 3'd0 || off == 3'd2) ? wdata[WIDTH-1:0] : o;
    assign dir_n[L +: WIDTH] = wr_p && off == 3'd1 ? wdata[WIDTH-1:0] : d;
    assign ie_n[L +: WIDTH] = wr_p && off == 3'd3 ? wdata[WIDTH-1:0] : ie_q[L +: WIDTH];
    assign edge_n[L +: WIDTH] = wr_p && off == 3'd4 ? wdata[WIDTH-1:0] : edge_q[L +: WIDTH];
    assign clr[L +: WIDTH] = (wr_p && off == 3'd5 ? wdata[WIDTH-1:0] : '0) |
                             (IFLAG_RC && rd_stb && rd_hit && sel_p && off == 3'd5 ? flag_q[L +: WIDTH] : '0);
  end
  always_comb begin
    rdata = 8'h00;
    for (int p = 0; p < N_PORTS; p++) rdata = rd_hit && sel == 3'(p) ? rd_mux[p] : rdata;
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      {out_q, dir_q, ie_q, edge_q, flag_q} <= '0;
      int_n <= 1'b1;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
      s3 <= s2;
      out_q <= out_n;
      dir_q <= dir_n;
      ie_q <= ie_n;
      edge_q <= edge_n;
      flag_q <= (flag_q & ~clr) | set;
      int_n <= ~|(flag_q & ie_q);
    end
  end
endmodule

// File: tb/tb_z180_gpio_bank.sv
// tb_z180_gpio_bank: directed checks of decode, registers, edge flags and interrupt timing
module tb_z180_gpio_bank;
  logic clock, rst_n, iorq_rd, rd_stb, wr_stb;
  logic [7:0] addr, wdata;
  logic [15:0] pin_in;
  logic rd_hit, int_n, rd_hit_rc, int_n_rc, rd_hit_w4, int_n_w4;
  logic [7:0] rdata, rdata_rc, rdata_w4, pin_w4, pin_out_w4, pin_oe_w4;
  logic [15:0] pin_out, pin_oe, pin_out_rc, pin_oe_rc;
  int checks = 0;
  int errors = 0;
  z180_gpio_bank dut (
    .clock(clock), .rst_n(rst_n), .addr(addr), .iorq_rd(iorq_rd), .rd_stb(rd_stb),
    .wr_stb(wr_stb), .wdata(wdata), .rd_hit(rd_hit), .rdata(rdata), .pin_in(pin_in),
    .pin_out(pin_out), .pin_oe(pin_oe), .int_n(int_n)
  );
  z180_gpio_bank #(.IFLAG_RC(1'b1)) dut_rc (
    .clock(clock), .rst_n(rst_n), .addr(addr), .iorq_rd(iorq_rd), .rd_stb(rd_stb),
    .wr_stb(wr_stb), .wdata(wdata), .rd_hit(rd_hit_rc), .rdata(rdata_rc), .pin_in(pin_in),
    .pin_out(pin_out_rc), .pin_oe(pin_oe_rc), .int_n(int_n_rc)
  );
  z180_gpio_bank #(.WIDTH(4)) dut_w4 (
    .clock(clock), .rst_n(rst_n), .addr(addr), .iorq_rd(iorq_rd), .rd_stb(rd_stb),
    .wr_stb(wr_stb), .wdata(wdata), .rd_hit(rd_hit_w4), .rdata(rdata_w4), .pin_in(pin_w4),
    .pin_out(pin_out_w4), .pin_oe(pin_oe_w4), .int_n(int_n_w4)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    wdata = d;
    wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    iorq_rd = 1'b1;
    #1;
    chk(tag, {8'h00, rdata}, {8'h00, exp});
    iorq_rd = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    {iorq_rd, rd_stb, wr_stb} = '0;
    addr = 8'h00;
    wdata = 8'h00;
    pin_in = 16'hFFFF;
    pin_w4 = 8'h00;
    tick(2);
    chk("rst_int_n", {15'b0, int_n}, 16'h0001);
    chk("rst_pin_oe", pin_oe, 16'h0000);
    chk("rst_pin_out", pin_out, 16'h0000);
    rst_n = 1'b1;
    tick();
    rdchk("data_1clk", 8'h60, 8'h00);
    tick();
    rdchk("data_2clk", 8'h60, 8'hFF);
    rdchk("rst_dir", 8'h61, 8'h00);
    rdchk("rst_out", 8'h62, 8'h00);
    rdchk("rst_ie", 8'h63, 8'h00);
    rdchk("rst_edge", 8'h64, 8'h00);
    rdchk("rst_iflag", 8'h65, 8'h00);
    tick(2);
    rdchk("no_spurious_flag", 8'h65, 8'h00);
    chk("no_spurious_int", {15'b0, int_n}, 16'h0001);
    wr(8'h61, 8'hF0);
    wr(8'h60, 8'hA5);
    chk("pin_oe", pin_oe, 16'h00F0);
    chk("pin_out", pin_out, 16'h00A5);
    rdchk("out_rb", 8'h62, 8'hA5);
    pin_in = 16'hFF3C;
    tick(2);
    rdchk("data_mix", 8'h60, 8'hAC);
    wr(8'h63, 8'h01);
    wr(8'h64, 8'h00);
    pin_in = 16'hFF3D;
    tick(2);
    rdchk("rise_2clk", 8'h65, 8'h00);
    tick();
    rdchk("rise_3clk", 8'h65, 8'h01);
    chk("rise_int_3clk", {15'b0, int_n}, 16'h0001);
    tick();
    chk("rise_int_4clk", {15'b0, int_n}, 16'h0000);
    wr(8'h65, 8'h01);
    rdchk("w1c_flag", 8'h65, 8'h00);
    chk("w1c_int_same", {15'b0, int_n}, 16'h0000);
    tick();
    chk("w1c_int_next", {15'b0, int_n}, 16'h0001);
    pin_in = 16'hFFBD;
    tick(3);
    wr(8'h64, 8'h80);
    wr(8'h63, 8'h80);
    pin_in = 16'hFF3D;
    tick(3);
    rdchk("fall_flag", 8'h65, 8'h80);
    tick();
    chk("fall_int", {15'b0, int_n}, 16'h0000);
    wr(8'h63, 8'h00);
    tick();
    chk("mask_int", {15'b0, int_n}, 16'h0001);
    rdchk("mask_flag_kept", 8'h65, 8'h80);
    pin_in = 16'hFF3C;
    tick(4);
    rdchk("ie0_edge_dropped", 8'h65, 8'h80);
    wr(8'h65, 8'hFF);
    wr(8'h64, 8'h00);
    wr(8'h63, 8'h01);
    pin_in = 16'hFF3D;
    tick(4);
    chk("col_pre_int", {15'b0, int_n}, 16'h0000);
    pin_in = 16'hFF3C;
    tick(3);
    pin_in = 16'hFF3D;
    tick(2);
    wr(8'h65, 8'h01);
    rdchk("col_w1c_flag", 8'h65, 8'h01);
    chk("col_w1c_int", {15'b0, int_n}, 16'h0000);
    tick();
    chk("col_w1c_int2", {15'b0, int_n}, 16'h0000);
    chk("rc_pre_int", {15'b0, int_n_rc}, 16'h0000);
    pin_in = 16'hFF3C;
    tick(3);
    pin_in = 16'hFF3D;
    tick(2);
    addr = 8'h65;
    iorq_rd = 1'b1;
    rd_stb = 1'b1;
    #1;
    chk("rc_rdata", {8'h00, rdata_rc}, 16'h0001);
    tick();
    rd_stb = 1'b0;
    chk("rc_col_flag", {8'h00, rdata_rc}, 16'h0001);
    chk("rc_col_int", {15'b0, int_n_rc}, 16'h0000);
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    chk("rc_cleared", {8'h00, rdata_rc}, 16'h0000);
    chk("rc0_kept", {8'h00, rdata}, 16'h0001);
    tick();
    iorq_rd = 1'b0;
    chk("rc_int_release", {15'b0, int_n_rc}, 16'h0001);
    addr = 8'h6F;
    iorq_rd = 1'b1;
    #1;
    chk("hit_6f", {15'b0, rd_hit}, 16'h0000);
    chk("rdata_6f", {8'h00, rdata}, 16'h0000);
    addr = 8'h70;
    #1;
    chk("hit_70", {15'b0, rd_hit}, 16'h0000);
    addr = 8'h5F;
    #1;
    chk("hit_5f", {15'b0, rd_hit}, 16'h0000);
    addr = 8'h6D;
    #1;
    chk("hit_6d", {15'b0, rd_hit}, 16'h0001);
    iorq_rd = 1'b0;
    wr(8'h70, 8'hFF);
    wr(8'h69, 8'h55);
    rdchk("p1_dir", 8'h69, 8'h55);
    chk("p1_pin_oe", pin_oe, 16'h55F0);
    wr(8'h6B, 8'hFF);
    addr = 8'h6B;
    iorq_rd = 1'b1;
    #1;
    chk("w4_ie", {8'h00, rdata_w4}, 16'h000F);
    iorq_rd = 1'b0;
    chk("pre_rst_int", {15'b0, int_n}, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_int", {15'b0, int_n}, 16'h0001);
    chk("mid_rst_oe", pin_oe, 16'h0000);
    rst_n = 1'b1;
    tick();
    rdchk("mid_rst_flag", 8'h65, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
